// File: rtl/rv2t_exec_sequencer.sv
// RV2T multi-cycle instruction sequencer: steps each instruction through
// fetch, decode, execute and memory/mul-div phases and owns the architectural PC.
module rv2t_exec_sequencer #(
    parameter int PC_WIDTH    = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sync_reset,
    input  logic                start,
    input  logic [PC_WIDTH-1:0] start_address,
    output logic                fetch_init,
    output logic [PC_WIDTH-1:0] fetch_PC,
    output logic                fetch_enable,
    input  logic                fetch_valid,
    input  logic                is_compressed,
    output logic                decode_enable,
    input  logic                ctl_LOAD,
    input  logic                ctl_STORE,
    input  logic                ctl_MUL_DIV_FUNCT3,
    input  logic                ctl_MRET,
    input  logic                ctl_WFI,
    input  logic                ctl_MISC_MEM,
    input  logic                exception_illegal_instruction,
    output logic                exe_enable,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic                mem_enable,
    input  logic                mem_done,
    output logic                mul_div_enable,
    input  logic                mul_div_done,
    input  logic                interrupt_pending,
    input  logic [PC_WIDTH-1:0] mtvec,
    input  logic [PC_WIDTH-1:0] mepc,
    output logic                trap_enter,
    output logic [3:0]          trap_cause,
    output logic [PC_WIDTH-1:0] trap_PC,
    output logic                mret_exec,
    output logic                active
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WAIT_MEM,
        S_WAIT_MD,
        S_TRAP,
        S_SLEEP
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT  = 8'(MEM_TIMEOUT);
    localparam logic [3:0] CAUSE_ILLEGAL = 4'h2;
    localparam logic [3:0] CAUSE_LOAD    = 4'h5;
    localparam logic [3:0] CAUSE_STORE   = 4'h7;
    localparam logic [3:0] CAUSE_IRQ     = 4'hB;

    state_t              state, state_nx;
    logic [PC_WIDTH-1:0] pc, pc_nx;
    logic [PC_WIDTH-1:0] tpc_q, tpc_nx;
    logic [3:0]          cause_q, cause_nx;
    logic [7:0]          cnt, cnt_nx;
    logic                comp_q, comp_nx;
    logic                store_q, store_nx;
    logic                mem_en_q, mem_en_nx;
    logic                md_en_q, md_en_nx;
    logic                mret_q, mret_nx;

    function automatic logic [PC_WIDTH-1:0] pc_advance(input logic [PC_WIDTH-1:0] cur,
                                                       input logic            comp);
        return cur + (comp ? PC_WIDTH'(2) : PC_WIDTH'(4));
    endfunction

    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        tpc_nx    = tpc_q;
        cause_nx  = cause_q;
        cnt_nx    = cnt;
        comp_nx   = comp_q;
        store_nx  = store_q;
        mem_en_nx = 1'b0;
        md_en_nx  = 1'b0;
        mret_nx   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    pc_nx    = start_address;
                    state_nx = S_INIT;
                end
            end
            S_INIT:   state_nx = S_FETCH;
            S_FETCH: begin
                if (fetch_valid) begin
                    comp_nx  = is_compressed;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: state_nx = S_EXECUTE;
            S_EXECUTE: begin
                if (exception_illegal_instruction) begin
                    cause_nx = CAUSE_ILLEGAL;
                    tpc_nx   = pc;
                    state_nx = S_TRAP;
                end else if (ctl_MRET) begin
                    pc_nx    = mepc;
                    mret_nx  = 1'b1;
                    state_nx = S_INIT;
                end else if (ctl_WFI) begin
                    pc_nx    = pc_advance(pc, comp_q);
                    state_nx = S_SLEEP;
                end else if (ctl_LOAD || ctl_STORE) begin
                    // A strobe carrying both is treated as a load.
                    store_nx  = !ctl_LOAD;
                    cnt_nx    = 8'd0;
                    mem_en_nx = 1'b1;
                    state_nx  = S_WAIT_MEM;
                end else if (ctl_MUL_DIV_FUNCT3) begin
                    md_en_nx = 1'b1;
                    state_nx = S_WAIT_MD;
                end else if (branch_taken) begin
                    pc_nx    = branch_target;
                    state_nx = S_INIT;
                end else if (ctl_MISC_MEM) begin
                    pc_nx    = pc_advance(pc, comp_q);
                    state_nx = S_INIT;
                end else begin
                    pc_nx    = pc_advance(pc, comp_q);
                    state_nx = S_FETCH;
                end
            end
            S_WAIT_MEM: begin
                if (mem_done) begin
                    pc_nx    = pc_advance(pc, comp_q);
                    state_nx = S_FETCH;
                end else if (cnt == TIMEOUT_CNT) begin
                    cause_nx = store_q ? CAUSE_STORE : CAUSE_LOAD;
                    tpc_nx   = pc;
                    state_nx = S_TRAP;
                end else begin
                    cnt_nx = cnt + 8'd1;
                end
            end
            S_WAIT_MD: begin
                if (mul_div_done) begin
                    pc_nx    = pc_advance(pc, comp_q);
                    state_nx = S_FETCH;
                end
            end
            S_TRAP: begin
                pc_nx    = mtvec;
                state_nx = S_INIT;
            end
            S_SLEEP: begin
                if (interrupt_pending) state_nx = S_FETCH;
            end
            default: state_nx = S_IDLE;
        endcase

        // Instruction boundary: a pending interrupt diverts FETCH entry into the trap.
        if (state_nx == S_FETCH && state != S_FETCH && interrupt_pending) begin
            cause_nx = CAUSE_IRQ;
            tpc_nx   = pc_nx;
            state_nx = S_TRAP;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            tpc_q    <= '0;
            cause_q  <= '0;
            cnt      <= '0;
            comp_q   <= 1'b0;
            store_q  <= 1'b0;
            mem_en_q <= 1'b0;
            md_en_q  <= 1'b0;
            mret_q   <= 1'b0;
        end else if (sync_reset) begin
            state    <= S_IDLE;
            pc       <= '0;
            tpc_q    <= '0;
            cause_q  <= '0;
            cnt      <= '0;
            comp_q   <= 1'b0;
            store_q  <= 1'b0;
            mem_en_q <= 1'b0;
            md_en_q  <= 1'b0;
            mret_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            tpc_q    <= tpc_nx;
            cause_q  <= cause_nx;
            cnt      <= cnt_nx;
            comp_q   <= comp_nx;
            store_q  <= store_nx;
            mem_en_q <= mem_en_nx;
            md_en_q  <= md_en_nx;
            mret_q   <= mret_nx;
        end
    end

    assign fetch_init     = (state == S_INIT);
    assign fetch_enable   = (state == S_FETCH);
    assign decode_enable  = (state == S_DECODE);
    assign exe_enable     = (state == S_EXECUTE);
    assign trap_enter     = (state == S_TRAP);
    assign active         = (state != S_IDLE);
    assign fetch_PC       = pc;
    assign trap_cause     = cause_q;
    assign trap_PC        = tpc_q;
    assign mem_enable     = mem_en_q;
    assign mul_div_enable = md_en_q;
    assign mret_exec      = mret_q;

endmodule

// File: tb/tb_rv2t_exec_sequencer.sv
// Directed bench for rv2t_exec_sequencer: cycle table for boot/ALU/branch flow,
// hand-written sequences for memory timeout, traps, sleep, MRET and reset.
module tb_rv2t_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset, sync_reset, start;
    logic [31:0] start_address, branch_target, mtvec, mepc;
    logic        fetch_init, fetch_enable, fetch_valid, is_compressed, decode_enable;
    logic        ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_MRET, ctl_WFI, ctl_MISC_MEM;
    logic        exception_illegal_instruction, exe_enable, branch_taken;
    logic        mem_enable, mem_done, mul_div_enable, mul_div_done, interrupt_pending;
    logic        trap_enter, mret_exec, active;
    logic [3:0]  trap_cause;
    logic [31:0] fetch_PC, trap_PC;

    int n_tests = 0;
    int n_fail  = 0;

    rv2t_exec_sequencer #(.PC_WIDTH(32), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .sync_reset(sync_reset), .start(start),
        .start_address(start_address), .fetch_init(fetch_init), .fetch_PC(fetch_PC),
        .fetch_enable(fetch_enable), .fetch_valid(fetch_valid), .is_compressed(is_compressed),
        .decode_enable(decode_enable), .ctl_LOAD(ctl_LOAD), .ctl_STORE(ctl_STORE),
        .ctl_MUL_DIV_FUNCT3(ctl_MUL_DIV_FUNCT3), .ctl_MRET(ctl_MRET), .ctl_WFI(ctl_WFI),
        .ctl_MISC_MEM(ctl_MISC_MEM), .exception_illegal_instruction(exception_illegal_instruction),
        .exe_enable(exe_enable), .branch_taken(branch_taken), .branch_target(branch_target),
        .mem_enable(mem_enable), .mem_done(mem_done), .mul_div_enable(mul_div_enable),
        .mul_div_done(mul_div_done), .interrupt_pending(interrupt_pending), .mtvec(mtvec),
        .mepc(mepc), .trap_enter(trap_enter), .trap_cause(trap_cause), .trap_PC(trap_PC),
        .mret_exec(mret_exec), .active(active)
    );

    always #5 clk = ~clk;

    // Enable bundle: {fetch_init, fetch_enable, decode, exe, mem, mul_div, trap_enter, mret_exec}
    logic [7:0] en;
    assign en = {fetch_init, fetch_enable, decode_enable, exe_enable,
                 mem_enable, mul_div_enable, trap_enter, mret_exec};

    localparam logic [7:0] E_NONE = 8'h00, INI = 8'h80, FE = 8'h40, DE = 8'h20, EX = 8'h10;
    localparam logic [7:0] ME = 8'h08, MD = 8'h04, TE = 8'h02, MR = 8'h01;

    // ctl bundle order: {LOAD, STORE, MUL_DIV, MRET, WFI, MISC_MEM}
    localparam logic [5:0] C_ALU = 6'b000000, C_LOAD = 6'b100000, C_STORE = 6'b010000;
    localparam logic [5:0] C_MD = 6'b001000, C_MRET = 6'b000100, C_WFI = 6'b000010;
    localparam logic [5:0] C_MISC = 6'b000001;

    typedef struct {
        logic        start;
        logic        fv;
        logic        comp;
        logic        br;
        logic [7:0]  exp_en;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: deliver an instruction immediately and leave EXECUTE with the given strobes.
    task automatic exec(input logic [5:0] ctl, input logic ill);
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
        tick();
        {ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_MRET, ctl_WFI, ctl_MISC_MEM} = ctl;
        exception_illegal_instruction = ill;
        tick();
        {ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_MRET, ctl_WFI, ctl_MISC_MEM} = 6'b0;
        exception_illegal_instruction = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sync_reset = 1'b0; start = 1'b0;
        start_address = 32'h100; branch_target = 32'h80; mtvec = 32'h400; mepc = 32'h300;
        fetch_valid = 1'b0; is_compressed = 1'b0; branch_taken = 1'b0;
        {ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_MRET, ctl_WFI, ctl_MISC_MEM} = 6'b0;
        exception_illegal_instruction = 1'b0;
        mem_done = 1'b0; mul_div_done = 1'b0; interrupt_pending = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, INI, 32'h100};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, FE,  32'h100};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, DE,  32'h100};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, EX,  32'h100};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, FE,  32'h104};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, DE,  32'h104};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, EX,  32'h104};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, FE,  32'h108};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, DE,  32'h108};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, EX,  32'h108};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, FE,  32'h10C};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, DE,  32'h10C};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, EX,  32'h10C};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, FE,  32'h10E};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b0, DE,  32'h10E};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, EX,  32'h10E};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, INI, 32'h80};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, FE,  32'h80};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, FE,  32'h80};

        repeat (2) @(posedge clk);
        #1;
        check("reset_en", {24'b0, en}, {24'b0, E_NONE});
        check("reset_active", {31'b0, active}, 32'h0);
        check("reset_pc", fetch_PC, 32'h0);
        check("reset_cause", {28'b0, trap_cause}, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start; fetch_valid = vecs[i].fv;
            is_compressed = vecs[i].comp; branch_taken = vecs[i].br;
            tick();
            check($sformatf("vec%0d_en", i), {24'b0, en}, {24'b0, vecs[i].exp_en});
            check($sformatf("vec%0d_pc", i), fetch_PC, vecs[i].exp_pc);
        end
        start = 1'b0; fetch_valid = 1'b0; is_compressed = 1'b0; branch_taken = 1'b0;

        // Load at 0x80 never completes: 5 cycles in WAIT_MEM, then access-fault trap.
        exec(C_LOAD, 1'b0);
        check("ld_mem_en", {24'b0, en}, {24'b0, ME});
        repeat (4) tick();
        check("ld_waiting", {24'b0, en}, {24'b0, E_NONE});
        tick();
        check("ld_trap_en", {24'b0, en}, {24'b0, TE});
        check("ld_trap_cause", {28'b0, trap_cause}, 32'h5);
        check("ld_trap_pc", trap_PC, 32'h80);
        tick();
        check("ld_mtvec_en", {24'b0, en}, {24'b0, INI});
        check("ld_mtvec_pc", fetch_PC, 32'h400);
        tick();

        // Load at 0x400 with mem_done on the timeout cycle: done wins.
        exec(C_LOAD, 1'b0);
        repeat (4) tick();
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("lddone_en", {24'b0, en}, {24'b0, FE});
        check("lddone_pc", fetch_PC, 32'h404);

        // Illegal outranks LOAD: trap cause 2, no memory pulse.
        exec(C_LOAD, 1'b1);
        check("ill_en", {24'b0, en}, {24'b0, TE});
        check("ill_cause", {28'b0, trap_cause}, 32'h2);
        check("ill_pc", trap_PC, 32'h404);
        tick();
        check("ill_mtvec", fetch_PC, 32'h400);
        tick();

        // Store timeout reports the store fault cause.
        exec(C_STORE, 1'b0);
        repeat (4) tick();
        tick();
        check("st_trap_en", {24'b0, en}, {24'b0, TE});
        check("st_trap_cause", {28'b0, trap_cause}, 32'h7);
        check("st_trap_pc", trap_PC, 32'h400);
        tick();
        tick();

        // FENCE.I at 0x400 refetches through INIT.
        exec(C_MISC, 1'b0);
        check("fence_en", {24'b0, en}, {24'b0, INI});
        check("fence_pc", fetch_PC, 32'h404);
        tick();

        // Mul/div at 0x404 finishing after two cycles.
        exec(C_MD, 1'b0);
        check("md_en", {24'b0, en}, {24'b0, MD});
        tick();
        check("md_wait", {24'b0, en}, {24'b0, E_NONE});
        mul_div_done = 1'b1;
        tick();
        mul_div_done = 1'b0;
        check("md_done_en", {24'b0, en}, {24'b0, FE});
        check("md_done_pc", fetch_PC, 32'h408);

        // WFI at 0x408, sleep 10 cycles, then interrupt trap with PC of the next instruction.
        exec(C_WFI, 1'b0);
        check("wfi_en", {24'b0, en}, {24'b0, E_NONE});
        check("wfi_pc", fetch_PC, 32'h40C);
        repeat (10) tick();
        check("sleep_en", {24'b0, en}, {24'b0, E_NONE});
        check("sleep_active", {31'b0, active}, 32'h1);
        interrupt_pending = 1'b1;
        tick();
        interrupt_pending = 1'b0;
        check("irq_en", {24'b0, en}, {24'b0, TE});
        check("irq_cause", {28'b0, trap_cause}, 32'hB);
        check("irq_pc", trap_PC, 32'h40C);
        tick();
        check("irq_mtvec", fetch_PC, 32'h400);
        tick();

        // MRET returns to mepc through INIT with a one-cycle mret_exec.
        exec(C_MRET, 1'b0);
        check("mret_en", {24'b0, en}, {24'b0, INI | MR});
        check("mret_pc", fetch_PC, 32'h300);
        tick();
        check("mret_after_en", {24'b0, en}, {24'b0, FE});

        // Async reset during WAIT_MD.
        exec(C_MD, 1'b0);
        tick();
        reset = 1'b1;
        #1;
        check("arst_en", {24'b0, en}, {24'b0, E_NONE});
        check("arst_active", {31'b0, active}, 32'h0);
        check("arst_pc", fetch_PC, 32'h0);
        check("arst_tpc", trap_PC, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mul_div_done = 1'b1;
        tick();
        mul_div_done = 1'b0;
        check("arst_mddone_en", {24'b0, en}, {24'b0, E_NONE});
        repeat (3) tick();
        check("arst_idle", {31'b0, active}, 32'h0);

        // Interrupt pending at the first FETCH entry after boot.
        start = 1'b1;
        tick();
        start = 1'b0;
        interrupt_pending = 1'b1;
        tick();
        interrupt_pending = 1'b0;
        check("bootirq_en", {24'b0, en}, {24'b0, TE});
        check("bootirq_cause", {28'b0, trap_cause}, 32'hB);
        check("bootirq_pc", trap_PC, 32'h100);
        tick();

        // Synchronous reset from INIT.
        sync_reset = 1'b1;
        tick();
        sync_reset = 1'b0;
        check("srst_active", {31'b0, active}, 32'h0);
        check("srst_pc", fetch_PC, 32'h0);
        check("srst_en", {24'b0, en}, {24'b0, E_NONE});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rv2t_exec_sequencer.md
# rv2t_exec_sequencer

Multi-cycle instruction sequencer for the RV2T core: drives the fetch → decode → execute → memory/mul-div phases one instruction at a time and owns the architectural PC. It consumes the decoder's control strobes and exception flag and handles PC redirects for branches, MRET, WFI sleep and FENCE.I. It enters traps on illegal instructions, memory timeouts and interrupts, issuing per-phase enables to the fetch, decode, execute, memory and mul/div units.

## Interface
- PC_WIDTH, 32, PC and address width
- MEM_TIMEOUT, 255, max cycles waiting for mem_done before access-fault trap (8-bit counter; legal 1..255)
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- sync_reset  in  1  synchronous reset, same effect as reset on next edge
- start  in  1  boot pulse; honoured only in IDLE
- start_address  in  PC_WIDTH  boot PC
- fetch_init  out  1  one-cycle pulse: load fetch_PC into the fetch unit
- fetch_PC  out  PC_WIDTH  architectural PC (registered)
- fetch_enable  out  1  request instruction
- fetch_valid  in  1  instruction available
- is_compressed  in  1  fetched instruction is 16-bit
- decode_enable  out  1  decode-phase strobe
- ctl_LOAD, ctl_STORE, ctl_MUL_DIV_FUNCT3, ctl_MRET, ctl_WFI, ctl_MISC_MEM  in  1 each  decoder strobes
- exception_illegal_instruction  in  1  decoder exception
- exe_enable  out  1  execute-phase strobe
- branch_taken  in  1  valid during exe_enable cycle
- branch_target  in  PC_WIDTH  redirect target
- mem_enable  out  1  one-cycle memory start pulse
- mem_done  in  1  memory access complete
- mul_div_enable  out  1  one-cycle mul/div start pulse
- mul_div_done  in  1  mul/div complete
- interrupt_pending  in  1  level, from CSR block
- mtvec, mepc  in  PC_WIDTH  trap vector / return address
- trap_enter  out  1  one-cycle pulse: CSR block captures trap_cause and trap_PC
- trap_cause  out  4  0x2 illegal, 0x5 load fault, 0x7 store fault, 0xB interrupt
- trap_PC  out  PC_WIDTH  PC of the faulting or interrupted instruction
- mret_exec  out  1  one-cycle pulse when MRET retires
- active  out  1  state != IDLE

## Operation
- States: IDLE, INIT, FETCH, DECODE, EXECUTE, WAIT_MEM, WAIT_MD, TRAP, SLEEP.
- IDLE: start=1 → PC ← start_address, go to INIT.
- INIT: assert fetch_init for one cycle → FETCH.
- FETCH: fetch_enable=1.
  - interrupt_pending sampled on FETCH entry (instruction boundary). If set, go to TRAP with cause 0xB and trap_PC=PC, without fetching.
  - Otherwise stay in FETCH until fetch_valid; latch is_compressed; → DECODE.
- DECODE: decode_enable=1 for exactly one cycle → EXECUTE.
- EXECUTE: exe_enable=1 for one cycle; ctl_* sampled this cycle. Priority, highest first:
  - illegal → TRAP, cause 0x2.
  - MRET → PC←mepc, mret_exec=1, → INIT.
  - WFI → PC←PC+len, → SLEEP.
  - LOAD/STORE → mem_enable pulse, remember which, → WAIT_MEM.
  - MUL_DIV → mul_div_enable pulse, → WAIT_MD.
  - branch_taken → PC←branch_target, → INIT.
  - MISC_MEM (FENCE.I) → PC←PC+len, → INIT (refetch flush).
  - otherwise → PC←PC+len, → FETCH.
  - len is 2 if compressed, else 4. PC arithmetic wraps modulo 2^PC_WIDTH.
- WAIT_MEM: 8-bit counter cleared on entry, incremented per cycle.
  - mem_done → PC←PC+len, → FETCH.
  - counter==MEM_TIMEOUT without mem_done → TRAP, cause 0x5 (load) or 0x7 (store).
  - mem_done in the same cycle as timeout: done wins.
- WAIT_MD: mul_div_done → PC←PC+len, → FETCH. No timeout.
- TRAP: trap_enter=1 with trap_cause and trap_PC valid; PC←mtvec; → INIT.
- SLEEP: all enables 0 until interrupt_pending, then → FETCH. The interrupt is taken on FETCH entry.
- start outside IDLE is ignored.

## Timing
- Reset (async or sync_reset) → IDLE. All outputs 0, PC=0, counter=0, latched flags 0. Mid-instruction reset abandons the instruction and issues no pulses.
- All outputs are registered or decoded from state only; none depend combinationally on inputs.
- Minimum instruction latency, non-memory: 3 cycles (FETCH with fetch_valid on first cycle, DECODE, EXECUTE).
- start pulse to first fetch_enable: 3 cycles (start accepted at edge 0; INIT with fetch_init during cycle 1; FETCH with fetch_enable from cycle 2). Same INIT latency applies after a redirect or trap.
- mem_enable and mul_div_enable assert in the first cycle of WAIT_MEM / WAIT_MD, exactly one cycle each.
- Memory load with mem_done k cycles after mem_enable: k+1 cycles in WAIT_MEM.

## Test plan
- Boot: start, start_address=0x100, three ALU ops with fetch_valid immediate → fetch_init once; fetch_PC goes 0x100, 0x104, 0x108; each instruction takes 3 cycles.
- Compressed plus branch: compressed op at 0x200, then branch_taken with target 0x80 → PC 0x202; then fetch_init with fetch_PC=0x80.
- Load timeout: MEM_TIMEOUT=4, ctl_LOAD, mem_done never asserted → trap_enter with cause 0x5, trap_PC = load PC, then fetch_PC=mtvec; mem_done arriving on the timeout cycle gives no trap.
- Illegal plus ctl_LOAD in the same EXECUTE cycle → cause 0x2 trap; no mem_enable.
- WFI then interrupt_pending after 10 cycles → SLEEP for 10 cycles; then trap cause 0xB with trap_PC = WFI PC+4; MRET afterwards → mret_exec pulse, fetch_PC=mepc.
- Reset asserted in WAIT_MD → all outputs 0 immediately; mul_div_done after release is ignored; active=0 until start.
